mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester arbiter that shares the single main-memory block port between the instruction cache and the data cache controller. Sits between both cache controllers and main memory, sequences one block transaction at a time, and returns per-requester busywait/readdata in the same busywait handshake the caches already use. Fixed data-side priority by default; round-robin optional.

## Interface

- ADDR_WIDTH, 28, block address width (byte address >> 4)
- DATA_WIDTH, 128, block data width

- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- i_mem_read  input  1  icache block read request, held until served
- i_mem_address  input  ADDR_WIDTH  icache block address
- i_mem_readdata  output  DATA_WIDTH  icache read data
- i_mem_busywait  output  1  icache stall
- d_mem_read  input  1  dcache block read request
- d_mem_write  input  1  dcache block write-back request
- d_mem_address  input  ADDR_WIDTH  dcache block address
- d_mem_writedata  input  DATA_WIDTH  dcache write-back data
- d_mem_readdata  output  DATA_WIDTH  dcache read data
- d_mem_busywait  output  1  dcache stall
- mem_read  output  1  memory read strobe, registered
- mem_write  output  1  memory write strobe, registered
- mem_address  output  ADDR_WIDTH  memory address, registered
- mem_writedata  output  DATA_WIDTH  memory write data, registered
- mem_readdata  input  DATA_WIDTH  memory read data
- mem_busywait  input  1  memory busy

## Operation

- States: IDLE, GRANT_I, GRANT_D. Internal flags: started, last_d (last grant was dcache).
- IDLE: i_req = i_mem_read; d_req = d_mem_read | d_mem_write. No request -> stay. One request -> grant it. Both -> dcache (see Configuration).
- On grant: latch address (and writedata/direction for dcache) into mem_* regs; assert mem_read or mem_write; clear started.
- dcache with d_mem_read and d_mem_write both high: treated as write.
- GRANT_x: started set on first cycle mem_busywait=1. done = started & ~mem_busywait (combinational).
- On done: next state IDLE; mem_read/mem_write cleared; mem_address/mem_writedata hold value.
- Requester busywait (combinational): x_mem_busywait = x_req & ~(state==GRANT_x & done). Ungranted pending requester sees busywait=1 throughout.
- x_mem_readdata = mem_readdata, passed through unconditionally; valid only in the done cycle of a read grant.
- Requester inputs ignored while another requester is granted; granted requester's inputs not re-sampled after grant.
- Requesters must change/drop request on the edge closing the done cycle; a still-asserted request in IDLE is a new transaction.

## Timing

- Reset (async, immediate): state=IDLE, started=0, last_d=0, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0; x_mem_busywait = x_req.
- Request seen in IDLE at cycle N -> mem strobe high in N+1.
- Memory raises busywait in N+2 or later; completion cycle M: requester busywait low, readdata valid in M.
- M+1: state IDLE, strobes low. Mandatory one-cycle turnaround: earliest next grant strobe at M+2.
- Minimum arbiter overhead: 2 cycles per transaction beyond memory latency.
- Memory never asserting mem_busywait -> arbiter waits indefinitely (memory contract violation, not recovered).
- Reset mid-transaction: strobes drop immediately, transaction abandoned; requester must reissue.

## Configuration

- ARB_ROUND_ROBIN_EN undefined: fixed priority, dcache wins every contention; last_d unused.
- ARB_ROUND_ROBIN_EN defined: on contention grant requester not granted last (last_d updated on every grant); uncontended grants unaffected; after reset first contention goes to dcache (last_d=0).

## Test plan

- Lone icache read 0x0000010, memory latency 5 -> mem_read high cycle 1, i_mem_busywait low in done cycle only, i_mem_readdata = mem_readdata, mem_read low next cycle.
- Lone dcache write 0x0000020, data 0xDEADBEEF_... -> mem_write=1, mem_address/mem_writedata latched, mem_read=0, d_mem_busywait drops on done.
- Both request same cycle, macro undefined -> dcache served first, icache busywait held high, icache strobe at done+2.
- Both requesting continuously 4 transactions, macro defined -> grant order D,I,D,I; undefined -> D,D,D,D.
- d_mem_read and d_mem_write both high -> write issued.
- Reset asserted mid GRANT_I -> strobes 0 same cycle, state IDLE; after release pending icache request regranted, mem_read at +1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module      : mem_port_arbiter
// Description : Shares the single main-memory block port between the icache
//               and dcache controllers, one block transaction at a time.
//               Fixed dcache priority; define ARB_ROUND_ROBIN_EN for
//               round-robin arbitration on contention.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  i_mem_read,
    input  logic [ADDR_WIDTH-1:0] i_mem_address,
    output logic [DATA_WIDTH-1:0] i_mem_readdata,
    output logic                  i_mem_busywait,

    input  logic                  d_mem_read,
    input  logic                  d_mem_write,
    input  logic [ADDR_WIDTH-1:0] d_mem_address,
    input  logic [DATA_WIDTH-1:0] d_mem_writedata,
    output logic [DATA_WIDTH-1:0] d_mem_readdata,
    output logic                  d_mem_busywait,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    input  logic                  mem_busywait
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_started;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_writedata;

    logic w_i_req;
    logic w_d_req;
    logic w_done;
    logic w_grant_i;
    logic w_grant_d;

    assign w_i_req = i_mem_read;
    assign w_d_req = d_mem_read | d_mem_write;

    // Completion needs memory to have gone busy at least once, so a stale
    // low busywait right after the strobe is not mistaken for the end.
    assign w_done  = r_started & ~mem_busywait;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_d;

    assign w_grant_d = w_d_req & (~w_i_req | ~r_last_d);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_d <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_grant_d) begin
                r_last_d <= 1'b1;
            end else if (w_grant_i) begin
                r_last_d <= 1'b0;
            end
        end
    end
`else
    assign w_grant_d = w_d_req;
`endif

    assign w_grant_i = w_i_req & ~w_grant_d;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_next = GRANT_D;
                end else if (w_grant_i) begin
                    w_state_next = GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (w_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Address and write data are captured once at grant and held afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_started       <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
        end else if (r_state == IDLE) begin
            if (w_grant_d) begin
                r_started       <= 1'b0;
                r_mem_address   <= d_mem_address;
                r_mem_writedata <= d_mem_writedata;
                r_mem_write     <= d_mem_write;
                r_mem_read      <= ~d_mem_write;
            end else if (w_grant_i) begin
                r_started     <= 1'b0;
                r_mem_address <= i_mem_address;
                r_mem_write   <= 1'b0;
                r_mem_read    <= 1'b1;
            end
        end else begin
            if (w_done) begin
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
            end else if (mem_busywait) begin
                r_started <= 1'b1;
            end
        end
    end

    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_address    = r_mem_address;
    assign mem_writedata  = r_mem_writedata;

    assign i_mem_busywait = w_i_req & ~((r_state == GRANT_I) & w_done);
    assign d_mem_busywait = w_d_req & ~((r_state == GRANT_D) & w_done);

    assign i_mem_readdata = mem_readdata;
    assign d_mem_readdata = mem_readdata;

endmodule

`default_nettype wire
